// File: rtl/cpu_types_pkg.sv
// Shared MIPS core types: machine word, opcode/funct encodings and fetch-stage state.
// Imported by every pipeline stage.
package cpu_types_pkg;

    localparam int WORD_W   = 32;
    localparam int OPCODE_W = 6;
    localparam int FUNCT_W  = 6;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [OPCODE_W-1:0] {
        RTYPE = 6'h00,
        J     = 6'h02,
        JAL   = 6'h03,
        BEQ   = 6'h04,
        BNE   = 6'h05,
        ADDI  = 6'h08,
        ADDIU = 6'h09,
        SLTI  = 6'h0a,
        SLTIU = 6'h0b,
        ANDI  = 6'h0c,
        ORI   = 6'h0d,
        XORI  = 6'h0e,
        LUI   = 6'h0f,
        LW    = 6'h23,
        SW    = 6'h2b,
        HALT  = 6'h3f
    } opcode_t;

    typedef enum logic [FUNCT_W-1:0] {
        SLL  = 6'h00,
        SRL  = 6'h02,
        JR   = 6'h08,
        ADD  = 6'h20,
        ADDU = 6'h21,
        SUB  = 6'h22,
        SUBU = 6'h23,
        AND  = 6'h24,
        OR   = 6'h25,
        XOR  = 6'h26,
        NOR  = 6'h27,
        SLT  = 6'h2a,
        SLTU = 6'h2b
    } funct_t;

    // sll $0,$0,0 -- the canonical bubble
    localparam word_t NOP_INSTR = 32'h0;

    typedef enum logic {
        FETCH,
        HALTED
    } fetch_state_t;

    // Fetch addresses are always word aligned.
    function automatic word_t word_align(input word_t addr);
        return addr & ~word_t'(3);
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bundles the fetch-stage signals for use by the core wrapper and bench harnesses.
interface fetch_unit_if;
    import cpu_types_pkg::*;

    logic    ihit;
    word_t   imemload;
    logic    imemREN;
    word_t   imemaddr;
    logic    stall;
    logic    redirect_en;
    word_t   redirect_pc;
    logic    halt_in;
    word_t   instr_out;
    word_t   npc_out;
    logic    valid_out;
    opcode_t opcode_out;
    funct_t  funct_out;
    logic    halted;

    modport fu (
        input  ihit, imemload, stall, redirect_en, redirect_pc, halt_in,
        output imemREN, imemaddr, instr_out, npc_out, valid_out,
        output opcode_out, funct_out, halted
    );

    modport tb (
        output ihit, imemload, stall, redirect_en, redirect_pc, halt_in,
        input  imemREN, imemaddr, instr_out, npc_out, valid_out,
        input  opcode_out, funct_out, halted
    );
endinterface

// File: rtl/fetch_unit_if_id_latch.sv
// Generic pipeline latch holding instruction word, PC+4 and a valid bit.
// Flush beats enable; with neither asserted the contents hold.
module if_id_latch
    import cpu_types_pkg::*;
#(
    parameter word_t NOP_WORD = NOP_INSTR
) (
    input  logic  CLK,
    input  logic  nRST,
    input  logic  enable,
    input  logic  flush,
    input  word_t instr_load,
    input  word_t npc_load,
    input  logic  valid_load,
    output word_t instr,
    output word_t npc,
    output logic  valid
);

    word_t instr_reg;
    word_t npc_reg;
    logic  valid_reg;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            instr_reg <= NOP_WORD;
            npc_reg   <= '0;
            valid_reg <= 1'b0;
        end else if (flush) begin
            instr_reg <= NOP_WORD;
            npc_reg   <= '0;
            valid_reg <= 1'b0;
        end else if (enable) begin
            instr_reg <= instr_load;
            npc_reg   <= npc_load;
            valid_reg <= valid_load;
        end
    end

    assign instr = instr_reg;
    assign npc   = npc_reg;
    assign valid = valid_reg;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, reads the icache and fills the IF/ID latch.
// Priority each FETCH cycle: redirect > halt > stall > ihit advance > bubble.
module fetch_unit
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT  = 32'h00000000,
    parameter word_t NOP_WORD = NOP_INSTR
) (
    input  logic    CLK,
    input  logic    nRST,
    input  logic    ihit,
    input  word_t   imemload,
    output logic    imemREN,
    output word_t   imemaddr,
    input  logic    stall,
    input  logic    redirect_en,
    input  word_t   redirect_pc,
    input  logic    halt_in,
    output word_t   instr_out,
    output word_t   npc_out,
    output logic    valid_out,
    output opcode_t opcode_out,
    output funct_t  funct_out,
    output logic    halted
);

    fetch_state_t state_reg, state_next;
    word_t        pc_reg, pc_next;
    word_t        pc_plus4;
    logic         latch_en;
    logic         latch_flush;

    assign pc_plus4 = pc_reg + word_t'(4);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg <= FETCH;
            pc_reg    <= PC_INIT;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        pc_next     = pc_reg;
        latch_en    = 1'b0;
        latch_flush = 1'b0;
        case (state_reg)
            FETCH: begin
                if (redirect_en) begin
                    // Any word returned this cycle is on the wrong path.
                    pc_next     = word_align(redirect_pc);
                    latch_flush = 1'b1;
                end else if (halt_in && valid_out) begin
                    state_next  = HALTED;
                    latch_flush = 1'b1;
                end else if (stall) begin
                    pc_next = pc_reg;
                end else if (ihit) begin
                    pc_next  = pc_plus4;
                    latch_en = 1'b1;
                end else begin
                    // Miss: insert a bubble so decode never sees a repeat.
                    latch_flush = 1'b1;
                end
            end
            HALTED: begin
                state_next = HALTED;
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

    if_id_latch #(
        .NOP_WORD (NOP_WORD)
    ) u_if_id (
        .CLK        (CLK),
        .nRST       (nRST),
        .enable     (latch_en),
        .flush      (latch_flush),
        .instr_load (imemload),
        .npc_load   (pc_plus4),
        .valid_load (1'b1),
        .instr      (instr_out),
        .npc        (npc_out),
        .valid      (valid_out)
    );

    assign imemaddr   = pc_reg;
    assign imemREN    = nRST && (state_reg == FETCH);
    assign halted     = (state_reg == HALTED);
    assign opcode_out = opcode_t'(instr_out[31:26]);
    assign funct_out  = funct_t'(instr_out[5:0]);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed test-plan sequences followed by
// randomized traffic, all compared against a cycle-level behavioural model.
module tb_fetch_unit;
    import cpu_types_pkg::*;

    localparam word_t PC_INIT = 32'h00000000;

    logic    CLK;
    logic    nRST;
    logic    ihit;
    word_t   imemload;
    logic    imemREN;
    word_t   imemaddr;
    logic    stall;
    logic    redirect_en;
    word_t   redirect_pc;
    logic    halt_in;
    word_t   instr_out;
    word_t   npc_out;
    logic    valid_out;
    opcode_t opcode_out;
    funct_t  funct_out;
    logic    halted;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Behavioural model state
    word_t m_pc;
    word_t m_instr;
    word_t m_npc;
    logic  m_valid;
    logic  m_halted;

    fetch_unit #(
        .PC_INIT  (PC_INIT),
        .NOP_WORD (32'h0)
    ) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .ihit        (ihit),
        .imemload    (imemload),
        .imemREN     (imemREN),
        .imemaddr    (imemaddr),
        .stall       (stall),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .halt_in     (halt_in),
        .instr_out   (instr_out),
        .npc_out     (npc_out),
        .valid_out   (valid_out),
        .opcode_out  (opcode_out),
        .funct_out   (funct_out),
        .halted      (halted)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        m_pc     = PC_INIT;
        m_instr  = 32'h0;
        m_npc    = 32'h0;
        m_valid  = 1'b0;
        m_halted = 1'b0;
    endtask

    task automatic model_step(input logic i_hit, input word_t i_load, input logic i_stall,
                              input logic i_redir, input word_t i_rpc, input logic i_halt);
        if (m_halted) begin
            // frozen until reset
        end else if (i_redir) begin
            m_pc    = {i_rpc[31:2], 2'b00};
            m_instr = 32'h0;
            m_valid = 1'b0;
        end else if (i_halt && m_valid) begin
            m_halted = 1'b1;
            m_instr  = 32'h0;
            m_valid  = 1'b0;
        end else if (i_stall) begin
            // hold everything
        end else if (i_hit) begin
            m_instr = i_load;
            m_npc   = m_pc + 32'd4;
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd4;
        end else begin
            m_instr = 32'h0;
            m_valid = 1'b0;
        end
    endtask

    task automatic check_outputs();
        logic [31:0] exp_op;
        logic [31:0] exp_fn;
        logic [31:0] exp_ren;
        exp_op  = {26'b0, m_instr[31:26]};
        exp_fn  = {26'b0, m_instr[5:0]};
        exp_ren = {31'b0, (nRST && !m_halted)};
        check_eq("imemaddr", imemaddr, m_pc);
        check_eq("imemREN", {31'b0, imemREN}, exp_ren);
        check_eq("instr_out", instr_out, m_instr);
        check_eq("valid_out", {31'b0, valid_out}, {31'b0, m_valid});
        check_eq("halted", {31'b0, halted}, {31'b0, m_halted});
        check_eq("opcode_out", 32'(opcode_out), exp_op);
        check_eq("funct_out", 32'(funct_out), exp_fn);
        if (m_valid)
            check_eq("npc_out", npc_out, m_npc);
    endtask

    task automatic cycle(input logic i_hit, input word_t i_load, input logic i_stall,
                         input logic i_redir, input word_t i_rpc, input logic i_halt);
        @(negedge CLK);
        check_outputs();
        ihit        = i_hit;
        imemload    = i_load;
        stall       = i_stall;
        redirect_en = i_redir;
        redirect_pc = i_rpc;
        halt_in     = i_halt;
        $display("cyc=%0d pc=%h ihit=%0b load=%h stall=%0b redir=%0b rpc=%h halt=%0b | instr=%h valid=%0b halted=%0b",
                 cyc, imemaddr, i_hit, i_load, i_stall, i_redir, i_rpc, i_halt,
                 instr_out, valid_out, halted);
        @(posedge CLK);
        model_step(i_hit, i_load, i_stall, i_redir, i_rpc, i_halt);
        cyc++;
    endtask

    // Asserts nRST between clock edges, checks the asynchronous clear, then
    // releases it away from the rising edge.
    task automatic pulse_reset();
        @(negedge CLK);
        #2;
        nRST        = 1'b0;
        ihit        = 1'b1;
        imemload    = $urandom;
        stall       = 1'b0;
        redirect_en = 1'b0;
        redirect_pc = 32'h0;
        halt_in     = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(posedge CLK);
        #1;
        check_outputs();
        @(negedge CLK);
        ihit = 1'b0;
        #1;
        nRST = 1'b1;
        $display("cyc=%0d reset pulse released", cyc);
        @(posedge CLK);
        model_step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        cyc++;
    endtask

    initial begin
        nRST        = 1'b0;
        ihit        = 1'b0;
        imemload    = 32'h0;
        stall       = 1'b0;
        redirect_en = 1'b0;
        redirect_pc = 32'h0;
        halt_in     = 1'b0;
        model_reset();

        pulse_reset();

        // Straight-line fetch
        cycle(1'b1, 32'h20010005, 1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 32'h20020007, 1'b0, 1'b0, 32'h0, 1'b0);
        // icache misses at PC=8
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 32'hdeadbeef, 1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 32'h00221820, 1'b0, 1'b0, 32'h0, 1'b0);
        // Stall with ihit, then release
        cycle(1'b1, 32'h8c040000, 1'b1, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 32'h8c040000, 1'b1, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 32'h8c040000, 1'b0, 1'b0, 32'h0, 1'b0);
        // Redirect beats stall and ihit
        cycle(1'b1, 32'h11111111, 1'b1, 1'b1, 32'h00000040, 1'b0);
        cycle(1'b1, 32'h3c05abcd, 1'b0, 1'b0, 32'h0, 1'b0);
        // Misaligned redirect target
        cycle(1'b1, 32'h22222222, 1'b0, 1'b1, 32'h00000043, 1'b0);
        cycle(1'b1, 32'h34a61234, 1'b0, 1'b0, 32'h0, 1'b0);
        // PC wrap at the top of memory
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 32'hfffffffc, 1'b0);
        cycle(1'b1, 32'h00000008, 1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 32'h24070001, 1'b0, 1'b0, 32'h0, 1'b0);
        // Halt beats stall; afterwards everything is ignored
        cycle(1'b1, 32'hffffffff, 1'b1, 1'b0, 32'h0, 1'b1);
        cycle(1'b1, 32'h20080009, 1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 32'h20080009, 1'b0, 1'b1, 32'h00000100, 1'b0);
        cycle(1'b1, 32'h20080009, 1'b1, 1'b0, 32'h0, 1'b1);
        pulse_reset();
        // Halt with a redirect in the same cycle is dropped
        cycle(1'b1, 32'h20090003, 1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 32'h0, 1'b0, 1'b1, 32'h00000200, 1'b1);
        // Halt while latch holds a bubble is ignored
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);

        // Randomized traffic
        for (int n = 0; n < 800; n++) begin
            if ((m_halted && $urandom_range(0, 3) == 0) || $urandom_range(0, 149) == 0) begin
                pulse_reset();
            end else begin
                cycle($urandom_range(0, 3) != 0,
                      word_t'($urandom),
                      $urandom_range(0, 4) == 0,
                      $urandom_range(0, 11) == 0,
                      word_t'($urandom),
                      $urandom_range(0, 29) == 0);
            end
        end

        @(negedge CLK);
        check_outputs();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
